// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: FSM state encoding and the canonical NOP word.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } fetch_state_t;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_watchdog.sv
// Timeout counter for the fetch stage: counts while inc is high, clears on clear,
// and flags expired in the cycle that would reach LIMIT.
module fetch_watchdog #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q;

  // Combinational so the FSM can leave S_FETCH on the threshold cycle itself.
  assign expired = inc && (cnt_q == CW'(LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (inc && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC capture, request/ack memory read, instruction hold
// with valid/ready to decode. Optional fetch timeout under FETCH_TIMEOUT_EN.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              pc_advance,
  output logic              fetch_fault
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              drop_q, drop_d;
  logic              expired;
  logic              unused_bits;

  assign unused_bits = ^pc_in[1:0];

`ifdef FETCH_TIMEOUT_EN
  logic wd_clear;
  logic wd_inc;

  assign wd_clear = (state_q != S_FETCH);
  assign wd_inc   = (state_q == S_FETCH) && !imem_ack;

  fetch_watchdog #(
    .LIMIT (TIMEOUT_CYC)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .inc     (wd_inc),
    .expired (expired)
  );

  assign fetch_fault = (state_q == S_FAULT);
`else
  logic unused_cfg;

  assign unused_cfg  = (TIMEOUT_CYC != 0);
  assign expired     = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  assign imem_addr = addr_q;
  assign instr_out = instr_q;
  assign instr_pc  = ipc_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    ipc_d       = ipc_q;
    instr_d     = instr_q;
    drop_d      = drop_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    pc_advance  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        addr_d  = {pc_in[ADDR_W-1:2], 2'b00};
        state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          // A flush arriving with the ack discards the word just like a pending drop.
          if (drop_q || flush) begin
            drop_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            instr_d = imem_rdata;
            ipc_d   = addr_q;
            state_d = S_HOLD;
          end
        end else if (expired) begin
          state_d = S_FAULT;
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end
      S_HOLD: begin
        instr_valid = 1'b1;
        if (flush) begin
          state_d = S_IDLE;
        end else if (instr_ready) begin
          pc_advance = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: begin
        state_d = S_FAULT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      ipc_q   <= '0;
      instr_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ipc_q   <= ipc_d;
      instr_q <= instr_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit; the bench plays PC register and memory.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] pc_in = '0;
  logic          flush = 1'b0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [DW-1:0] imem_rdata;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [DW-1:0] instr_out;
  logic [AW-1:0] instr_pc;
  logic          pc_advance;
  logic          fetch_fault;

  logic [31:0]   mem [0:127];
  int unsigned   ack_lat = 0;
  logic          ack_en = 1'b1;
  int unsigned   req_age;
  int            n_chk = 0;
  int            n_fail = 0;

  instr_fetch_unit #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_in       (pc_in),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .pc_advance  (pc_advance),
    .fetch_fault (fetch_fault)
  );

  always #5 clk = ~clk;

  // Memory model: acks once the request has been outstanding ack_lat full cycles.
  assign imem_ack   = ack_en && imem_req && (req_age >= ack_lat);
  assign imem_rdata = mem[imem_addr[8:2]];

  always @(posedge clk or posedge rst) begin
    if (rst) req_age <= 0;
    else if (!imem_req || imem_ack) req_age <= 0;
    else req_age <= req_age + 1;
  end

  task automatic test_reset();
    rst = 1'b1; pc_in = '0; flush = 1'b0; instr_ready = 1'b0; ack_en = 1'b1; ack_lat = 0;
    repeat (2) @(negedge clk);
    n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
    n_chk++; if (imem_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
    n_chk++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    n_chk++; if (instr_out !== '0 || instr_pc !== '0) begin n_fail++; $display("FAIL reset_data: out=%h pc=%h want 0/0", instr_out, instr_pc); end
    n_chk++; if (pc_advance !== 1'b0 || fetch_fault !== 1'b0) begin n_fail++; $display("FAIL reset_adv_fault: adv=%b fault=%b want 0/0", pc_advance, fetch_fault); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_release_idle: req=%b want 0", imem_req); end
  endtask

  task automatic test_first_fetch();
    ack_lat = 1; instr_ready = 1'b1;
    @(negedge clk);
    n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL first_req: req=%b addr=%h valid=%b want 1/0/0", imem_req, imem_addr, instr_valid); end
    @(negedge clk);
    n_chk++; if (imem_req !== 1'b1 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL first_ack_cycle: req=%b valid=%b want 1/0", imem_req, instr_valid); end
    @(negedge clk);
    n_chk++; if (instr_valid !== 1'b1 || instr_out !== 32'h0050_0093 || instr_pc !== 32'h0 || pc_advance !== 1'b1) begin
      n_fail++; $display("FAIL first_deliver: valid=%b out=%h pc=%h adv=%b want 1/00500093/0/1", instr_valid, instr_out, instr_pc, pc_advance); end
    @(posedge clk); #1 pc_in = 32'h4;
    @(negedge clk);
    n_chk++; if (pc_advance !== 1'b0 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL first_single_pulse: adv=%b valid=%b req=%b want 0/0/0", pc_advance, instr_valid, imem_req); end
    @(negedge clk);
    n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin n_fail++; $display("FAIL first_next_req: req=%b addr=%h want 1/4", imem_req, imem_addr); end
    @(negedge clk);
    @(negedge clk);
    n_chk++; if (instr_valid !== 1'b1 || instr_pc !== 32'h4 || instr_out !== INSTR_NOP || pc_advance !== 1'b1) begin
      n_fail++; $display("FAIL second_deliver: valid=%b pc=%h out=%h adv=%b want 1/4/%h/1", instr_valid, instr_pc, instr_out, pc_advance, INSTR_NOP); end
    @(posedge clk); #1 instr_ready = 1'b0; pc_in = 32'h10;
    @(negedge clk);
    n_chk++; if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL first_idle: valid=%b req=%b want 0/0", instr_valid, imem_req); end
  endtask

  // One accepted instruction per iteration; starts and ends with the DUT idle at a negedge.
  task automatic test_stream(input int n, input int stall_fix, input int lat_fix);
    for (int t = 0; t < n; t++) begin
      int          lat, stall, cyc;
      bit          early;
      logic [31:0] exp_pc, exp_in;
      lat    = (lat_fix < 0) ? int'($urandom_range(0, 3)) : lat_fix;
      stall  = (stall_fix < 0) ? int'($urandom_range(0, 5)) : stall_fix;
      early  = (stall_fix < 0) && ($urandom_range(0, 2) == 0);
      exp_pc = (pc_in >> 2) << 2;
      exp_in = mem[(pc_in >> 2) % 128];
      ack_lat = lat; instr_ready = early;
      @(negedge clk);
      n_chk++; if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin n_fail++; $display("FAIL stream_req: req=%b addr=%h want 1/%h", imem_req, imem_addr, exp_pc); end
      cyc = 0;
      while (instr_valid !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
      n_chk++; if (cyc != lat + 1) begin n_fail++; $display("FAIL stream_latency: %0d cycles want %0d", cyc, lat + 1); end
      n_chk++; if (instr_out !== exp_in || instr_pc !== exp_pc) begin n_fail++; $display("FAIL stream_data: out=%h pc=%h want %h/%h", instr_out, instr_pc, exp_in, exp_pc); end
      n_chk++; if (pc_advance !== early) begin n_fail++; $display("FAIL stream_adv_first: adv=%b want %b", pc_advance, early); end
      if (!early) begin
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          n_chk++; if (instr_valid !== 1'b1 || instr_out !== exp_in || instr_pc !== exp_pc || pc_advance !== 1'b0 || imem_req !== 1'b0) begin
            n_fail++; $display("FAIL stall_hold: valid=%b out=%h pc=%h adv=%b req=%b want 1/%h/%h/0/0", instr_valid, instr_out, instr_pc, pc_advance, imem_req, exp_in, exp_pc); end
        end
        @(posedge clk); #1 instr_ready = 1'b1;
        @(negedge clk);
        n_chk++; if (pc_advance !== 1'b1 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL stream_accept: adv=%b valid=%b want 1/1", pc_advance, instr_valid); end
      end
      @(posedge clk); #1;
      instr_ready = 1'b0;
      pc_in = $urandom_range(0, 511);
      flush = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      n_chk++; if (instr_valid !== 1'b0 || pc_advance !== 1'b0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL stream_idle: valid=%b adv=%b req=%b want 0/0/0", instr_valid, pc_advance, imem_req); end
      flush = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    test_stream(2, 5, -1);
  endtask

  task automatic test_misaligned();
    pc_in = 32'h6;
    test_stream(1, 0, 1);
  endtask

  task automatic test_flush_hold();
    pc_in = 32'h40; ack_lat = 0; instr_ready = 1'b0;
    @(negedge clk);
    n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin n_fail++; $display("FAIL fh_req: req=%b addr=%h want 1/40", imem_req, imem_addr); end
    @(negedge clk);
    n_chk++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40) begin n_fail++; $display("FAIL fh_hold: valid=%b pc=%h want 1/40", instr_valid, instr_pc); end
    @(posedge clk); #1 flush = 1'b1; instr_ready = 1'b1; pc_in = 32'h100;
    @(negedge clk);
    n_chk++; if (pc_advance !== 1'b0) begin n_fail++; $display("FAIL fh_no_adv: adv=%b want 0", pc_advance); end
    @(posedge clk); #1 flush = 1'b0; instr_ready = 1'b0;
    @(negedge clk);
    n_chk++; if (instr_valid !== 1'b0 || imem_req !== 1'b0 || pc_advance !== 1'b0) begin n_fail++; $display("FAIL fh_idle: valid=%b req=%b adv=%b want 0/0/0", instr_valid, imem_req, pc_advance); end
    test_stream(1, -1, -1);
  endtask

  task automatic test_flush_fetch();
    pc_in = 32'h80; ack_lat = 3; instr_ready = 1'b1;
    @(negedge clk);
    n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin n_fail++; $display("FAIL ff_req: req=%b addr=%h want 1/80", imem_req, imem_addr); end
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      flush = (k <= 2);
      if (k == 1) pc_in = 32'h100;
      @(negedge clk);
      n_chk++; if (instr_valid !== 1'b0 || pc_advance !== 1'b0 || imem_req !== (k <= 3) || (k <= 3 && imem_addr !== 32'h80)) begin
        n_fail++; $display("FAIL ff_drop k=%0d: valid=%b adv=%b req=%b addr=%h want 0/0/%b/80", k, instr_valid, pc_advance, imem_req, imem_addr, (k <= 3)); end
    end
    flush = 1'b0;
    test_stream(1, -1, -1);
  endtask

  task automatic test_reset_mid_fetch();
    ack_lat = 5;
    @(negedge clk);
    n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rmf_req: req=%b want 1", imem_req); end
    #2 rst = 1'b1;
    #1;
    n_chk++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== '0) begin n_fail++; $display("FAIL rmf_async: req=%b valid=%b addr=%h want 0/0/0", imem_req, instr_valid, imem_addr); end
    @(posedge clk); #1 rst = 1'b0; pc_in = 32'h20;
    @(negedge clk);
    n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rmf_idle: req=%b want 0", imem_req); end
    test_stream(1, 0, 0);
  endtask

  task automatic test_random_stream();
    test_stream(40, -1, -1);
  endtask

  task automatic test_timeout();
`ifdef FETCH_TIMEOUT_EN
    test_stream(1, 0, TO - 1);
    n_chk++; if (fetch_fault !== 1'b0) begin n_fail++; $display("FAIL to_ack_wins: fault=%b want 0", fetch_fault); end
    ack_en = 1'b0;
    @(negedge clk);
    for (int unsigned k = 1; k <= TO + 3; k++) begin
      @(negedge clk);
      n_chk++; if (imem_req !== (k < TO) || fetch_fault !== (k >= TO) || instr_valid !== 1'b0) begin
        n_fail++; $display("FAIL to_fault k=%0d: req=%b fault=%b valid=%b want %b/%b/0", k, imem_req, fetch_fault, instr_valid, (k < TO), (k >= TO)); end
    end
    #1 rst = 1'b1;
    #1;
    n_chk++; if (fetch_fault !== 1'b0) begin n_fail++; $display("FAIL to_rst_clear: fault=%b want 0", fetch_fault); end
    @(posedge clk); #1 rst = 1'b0; ack_en = 1'b1; pc_in = 32'h30;
    @(negedge clk);
    n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL to_idle: req=%b want 0", imem_req); end
    test_stream(1, 0, 0);
`else
    ack_en = 1'b0; ack_lat = 0; pc_in = 32'h30;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_chk++; if (imem_req !== 1'b1 || fetch_fault !== 1'b0) begin n_fail++; $display("FAIL nto_wait k=%0d: req=%b fault=%b want 1/0", k, imem_req, fetch_fault); end
    end
    ack_en = 1'b1;
    @(negedge clk);
    n_chk++; if (instr_valid !== 1'b1 || instr_pc !== 32'h30 || instr_out !== mem[12]) begin
      n_fail++; $display("FAIL nto_late_ack: valid=%b pc=%h out=%h want 1/30/%h", instr_valid, instr_pc, instr_out, mem[12]); end
    instr_ready = 1'b1;
    @(posedge clk); #1 instr_ready = 1'b0; pc_in = 32'h34;
    @(negedge clk);
    n_chk++; if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL nto_idle: valid=%b req=%b want 0/0", instr_valid, imem_req); end
`endif
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    mem[0] = 32'h0050_0093;
    mem[1] = INSTR_NOP;
    test_reset();
    test_first_fetch();
    test_backpressure();
    test_misaligned();
    test_flush_hold();
    test_flush_fetch();
    test_reset_mid_fetch();
    test_random_stream();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction-fetch stage directly downstream of the program counter register in the single/multi-cycle RISC-V core.
- Captures the current PC and issues a request/ack read to instruction memory.
- Holds the returned word in an instruction register and presents it to decode with a valid/ready handshake.
- Emits a one-cycle pc_advance pulse that the PC register uses as its load enable, so the PC only moves when an instruction has been consumed.

Parameters:
- ADDR_W, 32, width of PC and memory address.
- DATA_W, 32, instruction word width.
- TIMEOUT_CYC, 16, cycles in S_FETCH without ack before a fault (used only with FETCH_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- pc_in  in  ADDR_W  current PC from the program counter register.
- flush  in  1  branch/jump redirect; discard the in-flight or held instruction.
- imem_req  out  1  memory read request.
- imem_addr  out  ADDR_W  word-aligned fetch address.
- imem_ack  in  1  read data valid; sampled only while imem_req=1.
- imem_rdata  in  DATA_W  read data.
- instr_valid  out  1  instr_out/instr_pc valid to decode.
- instr_ready  in  1  decode accepts.
- instr_out  out  DATA_W  held instruction.
- instr_pc  out  ADDR_W  PC of the held instruction.
- pc_advance  out  1  one-cycle pulse: PC register loads next PC.
- fetch_fault  out  1  sticky timeout fault.

Behaviour:
- Reset (async, rst=1): state S_IDLE. imem_req=0, imem_addr=0, instr_valid=0, instr_out=0, instr_pc=0, pc_advance=0, fetch_fault=0, drop_q=0.
- States are S_IDLE, S_FETCH, S_HOLD, and S_FAULT (S_FAULT only with the macro).
- S_IDLE: next edge latches addr_q = {pc_in[ADDR_W-1:2], 2'b00} and goes to S_FETCH. Misaligned low PC bits are silently dropped.
- S_FETCH: imem_req=1 and imem_addr=addr_q, both stable until ack. Ack in the first request cycle is legal (combinational memory).
  - On ack with drop_q=0: latch instr_out=imem_rdata and instr_pc=addr_q, go to S_HOLD.
  - On ack with drop_q=1: discard the data, clear drop_q, go to S_IDLE.
- S_HOLD: instr_valid=1, and instr_out/instr_pc stay stable until the transfer. Transfer means instr_valid & instr_ready & !flush.
  - On transfer: pc_advance=1 for that cycle (combinational from state and inputs), then S_IDLE. The PC register updates on the same edge, so S_IDLE latches the new PC.
- Fetch latency: accepted instruction to the next imem_req is 2 cycles (one S_IDLE cycle). Reset deassertion to the first imem_req is 1 cycle.
- flush in S_HOLD: instr_valid is cleared at the next edge, state goes to S_IDLE, and there is no pc_advance. flush wins over a simultaneous instr_ready, so no transfer occurs.
- flush in S_FETCH: the memory request cannot be aborted. Set drop_q and keep requesting until ack, then discard.
- flush in S_IDLE: ignored. The upstream has already redirected the PC.
- flush while the drop is already pending: no further effect.
- Reset mid-fetch: the request drops immediately (async). The memory side must tolerate an abandoned request.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A counter clears on S_FETCH entry and increments each S_FETCH cycle without ack.
  - When it reaches TIMEOUT_CYC, go to S_FAULT: imem_req=0, instr_valid=0, fetch_fault=1 (sticky).
  - Only rst exits S_FAULT. Ack on the same cycle as the threshold wins, and no fault is raised.
- Undefined: no counter, S_FAULT is unreachable, fetch_fault is tied 0, and the port is kept so the interface is unchanged.

Decomposition:
- Shared package fetch_pkg holds the state encoding constants (S_IDLE=2'd0, S_FETCH=2'd1, S_HOLD=2'd2, S_FAULT=2'd3) and INSTR_NOP=32'h00000013 for bench use.
- One natural sub-module, fetch_watchdog: a loadable timeout counter with a clear input and an expired output, instantiated only under FETCH_TIMEOUT_EN.

Test Plan:
- Reset release, pc_in=0x0, ack 1 cycle after req with rdata=0x00500093, instr_ready=1: imem_addr=0x0, instr_valid with instr_out=0x00500093 and instr_pc=0x0, a single pc_advance pulse, next request at pc_in=0x4.
- Decode backpressure, instr_ready=0 for 5 cycles: instr_valid and data held stable, no pc_advance, no new imem_req; on ready, exactly one pc_advance.
- flush in S_HOLD together with instr_ready=1: no pc_advance, instr_valid low next cycle, next fetch from the new pc_in=0x100.
- flush in S_FETCH with ack 3 cycles later: rdata never appears on instr_valid, then a refetch at pc_in=0x100.
- Misaligned pc_in=0x6: imem_addr=0x4 and instr_pc=0x4.
- With FETCH_TIMEOUT_EN and TIMEOUT_CYC=16, no ack: fetch_fault=1 after 16 cycles, imem_req drops; rst clears it. Ack on cycle 16: no fault.
